// File: rtl/rr_arb8_pkg.sv
// Shared types and constants for the rr_arb8 round-robin arbiter and its picker.
package rr_arb8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Pointer value that makes the first search after reset start at requester 0.
    localparam logic [IDX_W-1:0] LAST_RST = 3'd7;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: rotate requests so the slot after `last` is
// bit 0, take the lowest set bit, and rotate the result back.
module rr_pick8
    import rr_arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    logic [IDX_W-1:0] w_base;
    logic [N_REQ-1:0] w_rot;
    logic [N_REQ-1:0] w_rot_oh;
    logic [IDX_W-1:0] w_ofs;

    assign w_base = last + IDX_W'(1);
    assign any    = |req;

    // Index arithmetic is IDX_W bits wide, so the modulo-8 wrap comes for free.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_rot[k] = req[w_base + IDX_W'(k)];
        end
    end

    always_comb begin
        w_ofs = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_ofs = IDX_W'(k);
            end
        end
    end

    assign w_rot_oh = any ? (N_REQ'(1) << w_ofs) : '0;

    always_comb begin
        pick_oh = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pick_oh[w_base + IDX_W'(k)] = w_rot_oh[k];
        end
    end

    assign pick_idx = any ? (w_base + w_ofs) : '0;

endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with grant locking and registered outputs.
// Define RR_ARB8_TIMEOUT_EN to bound each grant to MAX_HOLD cycles and pulse tmo.
module rr_arb8 #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     gnt_vld,
    output logic                     tmo
);

    import rr_arb8_pkg::*;

    if (N_REQ != 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_params
        $error("rr_arb8: N_REQ must be 8 and MAX_HOLD must be in 1..255");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_last_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_gnt_idx_nxt;
    logic             r_gnt_vld;
    logic             w_gnt_vld_nxt;

    logic [N_REQ-1:0] w_pick_oh;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_any;
    logic             w_timeout;

    rr_pick8 u_pick (
        .req      (req),
        .last     (r_last),
        .pick_oh  (w_pick_oh),
        .pick_idx (w_pick_idx),
        .any      (w_any)
    );

`ifdef RR_ARB8_TIMEOUT_EN
    logic [7:0] r_hold_cnt;
    logic       r_tmo;

    assign w_timeout = (r_state == BUSY) && req[r_last]
                     && (r_hold_cnt == 8'(MAX_HOLD - 1));

    // Counter sits at zero in IDLE, so it is already cleared on entry to BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_tmo      <= 1'b0;
        end else begin
            r_hold_cnt <= (r_state == BUSY) ? r_hold_cnt + 8'd1 : 8'd0;
            r_tmo      <= w_timeout;
        end
    end

    assign tmo = r_tmo;
`else
    assign w_timeout = 1'b0;
    assign tmo       = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_gnt_vld_nxt = r_gnt_vld;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt   = BUSY;
                    w_last_nxt    = w_pick_idx;
                    w_gnt_nxt     = w_pick_oh;
                    w_gnt_idx_nxt = w_pick_idx;
                    w_gnt_vld_nxt = 1'b1;
                end
            end
            BUSY: begin
                // Releasing always passes through IDLE, giving one gap cycle between owners.
                if (!req[r_last] || w_timeout) begin
                    w_state_nxt   = IDLE;
                    w_gnt_nxt     = '0;
                    w_gnt_idx_nxt = '0;
                    w_gnt_vld_nxt = 1'b0;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= LAST_RST;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_gnt_vld <= w_gnt_vld_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;

endmodule
